// File: rtl/recorrido_izq_der_serial.sv
// recorrido_izq_der_serial: bit-serial MSB-first magnitude comparator with start/done handshake
module recorrido_izq_der_serial #(
  parameter int N          = 8,
  parameter bit EARLY_EXIT = 1'b1,
  parameter int CW         = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  wordA,
  input  logic [N-1:0]  wordB,
  output logic          busy,
  output logic          done,
  output logic          res_valid,
  output logic          mayor,
  output logic          menor,
  output logic          igual,
  output logic [CW-1:0] ciclos
);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t        r_state, w_next;
  logic [N-1:0]  r_a, r_b;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt, w_cnt, r_ciclos;
  logic          r_diff, r_valid, r_mayor, r_menor, r_igual;
  logic          w_hit, w_last, w_accept;
  always_comb begin
    w_hit    = !r_diff && (r_a[r_idx] != r_b[r_idx]);
    w_last   = (EARLY_EXIT && w_hit) || (r_idx == '0);
    w_cnt    = (r_cnt == CW'(N)) ? r_cnt : r_cnt + CW'(1);
    w_accept = start && (r_state != SCAN);
    w_next   = w_accept ? SCAN : (r_state == SCAN) ? (w_last ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_diff   <= 1'b0;
      r_valid  <= 1'b0;
      r_mayor  <= 1'b0;
      r_menor  <= 1'b0;
      r_igual  <= 1'b0;
      r_ciclos <= '0;
    end else if (w_accept) begin
      r_a     <= wordA;
      r_b     <= wordB;
      r_idx   <= IW'(N - 1);
      r_cnt   <= '0;
      r_diff  <= 1'b0;
      r_valid <= 1'b0;
      r_mayor <= 1'b0;
      r_menor <= 1'b0;
      r_igual <= 1'b0;
    end else if (r_state == SCAN) begin
      r_cnt <= w_cnt;
      if (w_hit) begin
        r_diff  <= 1'b1;
        r_mayor <= r_a[r_idx];
        r_menor <= r_b[r_idx];
      end
      // result becomes visible in the DONE cycle, including this edge's finding
      if (w_last) begin
        r_valid  <= 1'b1;
        r_ciclos <= w_cnt;
        r_igual  <= !(r_diff || w_hit);
      end else begin
        r_idx <= r_idx - IW'(1);
      end
    end
  end
  assign busy      = (r_state == SCAN);
  assign done      = (r_state == DONE);
  assign res_valid = r_valid;
  assign mayor     = r_mayor;
  assign menor     = r_menor;
  assign igual     = r_igual;
  assign ciclos    = r_ciclos;
endmodule
